// File: rtl/draw_layers.sv
// N-layer priority pixel compositor with a frame-counted screen-flash effect.
// Two registered stages: layer select, then blanking and flash substitution.
module draw_layers #(
    parameter int NLAYERS      = 4,
    parameter int CW           = 3,
    parameter int FLASH_PERIOD = 8,
    parameter int FLASH_BLINKS = 3,
    localparam int IDW         = (NLAYERS > 1) ? $clog2(NLAYERS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      visible,
    input  logic                      frame_start,
    input  logic [NLAYERS-1:0]        layer_en,
    input  logic [NLAYERS*(CW+1)-1:0] in_layers,
    input  logic [CW-1:0]             bg_color,
    input  logic                      flash_req,
    input  logic [CW-1:0]             flash_color,
    output logic [CW-1:0]             o_rgb,
    output logic                      o_hit,
    output logic [IDW-1:0]            o_layer_id,
    output logic                      flash_active
);

    localparam int FCW = $clog2(FLASH_PERIOD + 1);
    localparam int BCW = $clog2(FLASH_BLINKS + 1);
    localparam logic [FCW-1:0] CNT_LAST = FCW'(FLASH_PERIOD - 1);
    localparam logic [BCW-1:0] BL_INIT  = BCW'(FLASH_BLINKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    logic [CW-1:0]  w_color;
    logic           w_hit;
    logic [IDW-1:0] w_id;
    logic [CW-1:0]  r_s1_color;
    logic           r_s1_hit;
    logic [IDW-1:0] r_s1_id;
    logic           r_s1_vis;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [FCW-1:0] r_frame_cnt;
    logic [FCW-1:0] w_frame_cnt_nxt;
    logic [BCW-1:0] r_blinks_left;
    logic [BCW-1:0] w_blinks_nxt;

    // Priority select: scan from lowest priority upward so layer 0 overrides last.
    always_comb begin
        w_hit   = 1'b0;
        w_id    = '0;
        w_color = bg_color;
        for (int i = NLAYERS - 1; i >= 0; i--) begin
            w_color = (in_layers[i*(CW+1)+CW] && layer_en[i]) ? in_layers[i*(CW+1) +: CW] : w_color;
            w_id    = (in_layers[i*(CW+1)+CW] && layer_en[i]) ? IDW'(i) : w_id;
            w_hit   = (in_layers[i*(CW+1)+CW] && layer_en[i]) ? 1'b1 : w_hit;
        end
    end

    // Stage 1 register: winning layer colour, hit flag, index and visibility.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_color <= '0;
            r_s1_hit   <= 1'b0;
            r_s1_id    <= '0;
            r_s1_vis   <= 1'b0;
        end else begin
            r_s1_color <= w_color;
            r_s1_hit   <= w_hit;
            r_s1_id    <= w_id;
            r_s1_vis   <= visible;
        end
    end

    // Flash sequencer next state; a request always restarts at the first ON frame.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_blinks_nxt    = r_blinks_left;
        if (flash_req) begin
            w_state_nxt     = ST_ON;
            w_frame_cnt_nxt = '0;
            w_blinks_nxt    = BL_INIT;
        end else if (frame_start) begin
            case (r_state)
                ST_ON: begin
                    if (r_frame_cnt == CNT_LAST) begin
                        w_frame_cnt_nxt = '0;
                        w_state_nxt     = (r_blinks_left == '0) ? ST_IDLE : ST_OFF;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FCW'(1);
                    end
                end
                ST_OFF: begin
                    if (r_frame_cnt == CNT_LAST) begin
                        w_frame_cnt_nxt = '0;
                        w_blinks_nxt    = r_blinks_left - BCW'(1);
                        w_state_nxt     = ST_ON;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FCW'(1);
                    end
                end
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_cnt_nxt = '0;
                    w_blinks_nxt    = '0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Flash sequencer state, counters and the active flag that mirrors the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_frame_cnt   <= '0;
            r_blinks_left <= '0;
            flash_active  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_blinks_left <= w_blinks_nxt;
            flash_active  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Stage 2: blank outside the active area, otherwise overlay the flash colour.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_rgb      <= '0;
            o_hit      <= 1'b0;
            o_layer_id <= '0;
        end else if (!r_s1_vis) begin
            o_rgb      <= '0;
            o_hit      <= 1'b0;
            o_layer_id <= '0;
        end else begin
            o_rgb      <= (r_state == ST_ON) ? flash_color : r_s1_color;
            o_hit      <= r_s1_hit;
            o_layer_id <= r_s1_id;
        end
    end

endmodule

// File: tb/tb_draw_layers.sv
// Bench for draw_layers: three parameterisations checked every cycle against a
// frame-counting reference model, plus vector tables and flash/reset sequences.
module tb_draw_layers;

    localparam int NL_A = 4, CW_A = 3,  FP_A = 2, FB_A = 2;
    localparam int NL_B = 1, CW_B = 12, FP_B = 1, FB_B = 1;
    localparam int NL_C = 8, CW_C = 12, FP_C = 3, FB_C = 3;

    int p_nl[3] = '{NL_A, NL_B, NL_C};
    int p_cw[3] = '{CW_A, CW_B, CW_C};
    int p_fp[3] = '{FP_A, FP_B, FP_C};
    int p_fb[3] = '{FB_A, FB_B, FB_C};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         vis_v [3];
    logic         fs_v  [3];
    logic         fr_v  [3];
    logic [7:0]   en_v  [3];
    logic [103:0] lay_v [3];
    logic [11:0]  bg_v  [3];
    logic [11:0]  fc_v  [3];

    logic [2:0]  rgb_a;  logic hit_a; logic [1:0] id_a; logic fa_a;
    logic [11:0] rgb_b;  logic hit_b; logic [0:0] id_b; logic fa_b;
    logic [11:0] rgb_c;  logic hit_c; logic [2:0] id_c; logic fa_c;

    draw_layers #(.NLAYERS(NL_A), .CW(CW_A), .FLASH_PERIOD(FP_A), .FLASH_BLINKS(FB_A)) dut_a (
        .clock(clk), .reset(rst), .visible(vis_v[0]), .frame_start(fs_v[0]),
        .layer_en(en_v[0][NL_A-1:0]), .in_layers(lay_v[0][NL_A*(CW_A+1)-1:0]),
        .bg_color(bg_v[0][CW_A-1:0]), .flash_req(fr_v[0]), .flash_color(fc_v[0][CW_A-1:0]),
        .o_rgb(rgb_a), .o_hit(hit_a), .o_layer_id(id_a), .flash_active(fa_a));

    draw_layers #(.NLAYERS(NL_B), .CW(CW_B), .FLASH_PERIOD(FP_B), .FLASH_BLINKS(FB_B)) dut_b (
        .clock(clk), .reset(rst), .visible(vis_v[1]), .frame_start(fs_v[1]),
        .layer_en(en_v[1][NL_B-1:0]), .in_layers(lay_v[1][NL_B*(CW_B+1)-1:0]),
        .bg_color(bg_v[1][CW_B-1:0]), .flash_req(fr_v[1]), .flash_color(fc_v[1][CW_B-1:0]),
        .o_rgb(rgb_b), .o_hit(hit_b), .o_layer_id(id_b), .flash_active(fa_b));

    draw_layers #(.NLAYERS(NL_C), .CW(CW_C), .FLASH_PERIOD(FP_C), .FLASH_BLINKS(FB_C)) dut_c (
        .clock(clk), .reset(rst), .visible(vis_v[2]), .frame_start(fs_v[2]),
        .layer_en(en_v[2][NL_C-1:0]), .in_layers(lay_v[2][NL_C*(CW_C+1)-1:0]),
        .bg_color(bg_v[2][CW_C-1:0]), .flash_req(fr_v[2]), .flash_color(fc_v[2][CW_C-1:0]),
        .o_rgb(rgb_c), .o_hit(hit_c), .o_layer_id(id_c), .flash_active(fa_c));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: flash phase derived from frames elapsed since the request.
    logic        m_act  [3];
    int          m_k    [3];
    logic        m_s1v  [3];
    logic        m_s1h  [3];
    int          m_s1id [3];
    logic [11:0] m_s1c  [3];
    logic [11:0] e_rgb  [3];
    logic        e_hit  [3];
    int          e_id   [3];
    logic        e_fa   [3];

    typedef struct {
        logic [3:0]  en;
        logic [15:0] lay;
        logic [2:0]  bg;
        logic        vis;
        logic [2:0]  rgb;
        logic        hit;
        logic [1:0]  id;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [11:0] msk(input int w);
        logic [12:0] t;
        t = (13'd1 << w) - 13'd1;
        return t[11:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int u);
        logic        fon;
        logic        found;
        logic [11:0] col;
        int          id;
        int          cw;
        if (rst) begin
            m_act[u] = 1'b0; m_k[u] = 0;
            m_s1v[u] = 1'b0; m_s1h[u] = 1'b0; m_s1id[u] = 0; m_s1c[u] = 12'd0;
            e_rgb[u] = 12'd0; e_hit[u] = 1'b0; e_id[u] = 0;
        end else begin
            cw  = p_cw[u];
            fon = m_act[u] && (((m_k[u] / p_fp[u]) % 2) == 0);
            if (m_s1v[u]) begin
                e_rgb[u] = fon ? (fc_v[u] & msk(cw)) : m_s1c[u];
                e_hit[u] = m_s1h[u];
                e_id[u]  = m_s1id[u];
            end else begin
                e_rgb[u] = 12'd0; e_hit[u] = 1'b0; e_id[u] = 0;
            end
            found = 1'b0; id = 0; col = bg_v[u] & msk(cw);
            for (int i = 0; i < p_nl[u]; i++) begin
                if (!found && en_v[u][i] && lay_v[u][i*(cw+1)+cw]) begin
                    found = 1'b1;
                    id    = i;
                    col   = 12'd0;
                    for (int b = 0; b < cw; b++) col[b] = lay_v[u][i*(cw+1)+b];
                end
            end
            m_s1v[u] = vis_v[u]; m_s1h[u] = found; m_s1id[u] = id; m_s1c[u] = col;
            if (fr_v[u]) begin
                m_act[u] = 1'b1; m_k[u] = 0;
            end else if (fs_v[u] && m_act[u]) begin
                m_k[u]++;
                if (m_k[u] == (2 * p_fb[u] - 1) * p_fp[u]) begin
                    m_act[u] = 1'b0; m_k[u] = 0;
                end
            end
        end
        e_fa[u] = m_act[u];
    endtask

    task automatic tick();
        for (int u = 0; u < 3; u++) model_step(u);
        @(posedge clk);
        #1;
        chk("a_rgb", rgb_a, e_rgb[0]); chk("a_hit", hit_a, e_hit[0]);
        chk("a_id", id_a, e_id[0]);    chk("a_flash", fa_a, e_fa[0]);
        chk("b_rgb", rgb_b, e_rgb[1]); chk("b_hit", hit_b, e_hit[1]);
        chk("b_id", id_b, e_id[1]);    chk("b_flash", fa_b, e_fa[1]);
        chk("c_rgb", rgb_c, e_rgb[2]); chk("c_hit", hit_c, e_hit[2]);
        chk("c_id", id_c, e_id[2]);    chk("c_flash", fa_c, e_fa[2]);
    endtask

    task automatic run_flash_seq(input string tag);
        for (int f = 0; f < 6; f++) begin
            tick(); tick(); tick();
            chk({tag, "_rgb"}, rgb_a, (f == 2 || f == 3) ? 3'b100 : 3'b111);
            chk({tag, "_active"}, fa_a, 1'b1);
            fs_v[0] = 1'b1; tick(); fs_v[0] = 1'b0;
        end
        tick(); tick(); tick();
        chk({tag, "_end_rgb"}, rgb_a, 3'b100);
        chk({tag, "_end_active"}, fa_a, 1'b0);
    endtask

    initial begin
        tbl[0] = '{4'b1111, 16'hA0D0, 3'b000, 1'b1, 3'b101, 1'b1, 2'd1};
        tbl[1] = '{4'b1101, 16'hA0D0, 3'b000, 1'b1, 3'b010, 1'b1, 2'd3};
        tbl[2] = '{4'b0000, 16'hBCDE, 3'b001, 1'b1, 3'b001, 1'b0, 2'd0};
        tbl[3] = '{4'b1111, 16'h0000, 3'b001, 1'b1, 3'b001, 1'b0, 2'd0};
        tbl[4] = '{4'b1111, 16'h000E, 3'b001, 1'b0, 3'b000, 1'b0, 2'd0};
        tbl[5] = '{4'b1110, 16'hBCDE, 3'b000, 1'b1, 3'b101, 1'b1, 2'd1};
        tbl[6] = '{4'b1000, 16'hBCDE, 3'b000, 1'b1, 3'b011, 1'b1, 2'd3};
        tbl[7] = '{4'b0100, 16'hBCDE, 3'b110, 1'b1, 3'b100, 1'b1, 2'd2};

        for (int u = 0; u < 3; u++) begin
            vis_v[u] = 1'b0; fs_v[u] = 1'b0; fr_v[u] = 1'b0; en_v[u] = 8'd0;
            lay_v[u] = 104'd0; bg_v[u] = 12'd0; fc_v[u] = 12'd0;
        end
        rst = 1'b1;
        tick(); tick();
        chk("reset_rgb", rgb_a, 3'b000);
        chk("reset_active", fa_a, 1'b0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            en_v[0]  = {4'b0000, tbl[v].en};
            lay_v[0] = {88'd0, tbl[v].lay};
            bg_v[0]  = {9'd0, tbl[v].bg};
            vis_v[0] = tbl[v].vis;
            tick(); tick();
            chk($sformatf("tbl%0d_rgb", v), rgb_a, tbl[v].rgb);
            chk($sformatf("tbl%0d_hit", v), hit_a, tbl[v].hit);
            chk($sformatf("tbl%0d_id", v), id_a, tbl[v].id);
        end

        en_v[0] = 8'h0F; lay_v[0] = 104'h000E; bg_v[0] = 12'h001; vis_v[0] = 1'b1;
        tick(); tick();
        chk("blank_before", rgb_a, 3'b110);
        vis_v[0] = 1'b0;
        tick();
        chk("blank_lat1", rgb_a, 3'b110);
        tick();
        chk("blank_lat2_rgb", rgb_a, 3'b000);
        chk("blank_lat2_hit", hit_a, 1'b0);

        lay_v[0] = 104'h0C00; bg_v[0] = 12'h000; vis_v[0] = 1'b1; fc_v[0] = 12'h007;
        tick(); tick();
        fr_v[0] = 1'b1; tick(); fr_v[0] = 1'b0;
        run_flash_seq("flash");

        fr_v[0] = 1'b1; tick(); fr_v[0] = 1'b0;
        for (int f = 0; f < 2; f++) begin
            tick(); fs_v[0] = 1'b1; tick(); fs_v[0] = 1'b0;
        end
        tick(); tick(); tick();
        chk("restart_off_rgb", rgb_a, 3'b100);
        fr_v[0] = 1'b1; fs_v[0] = 1'b1; tick(); fr_v[0] = 1'b0; fs_v[0] = 1'b0;
        run_flash_seq("restart");

        fr_v[0] = 1'b1; tick(); fr_v[0] = 1'b0;
        tick(); tick();
        chk("pre_reset_rgb", rgb_a, 3'b111);
        rst = 1'b1; tick();
        chk("rst_rgb", rgb_a, 3'b000);
        chk("rst_hit", hit_a, 1'b0);
        chk("rst_active", fa_a, 1'b0);
        lay_v[0] = 104'h000B;
        rst = 1'b0; tick();
        chk("post_rst_lat1", rgb_a, 3'b000);
        tick();
        chk("post_rst_rgb", rgb_a, 3'b011);
        chk("post_rst_hit", hit_a, 1'b1);
        chk("post_rst_id", id_a, 2'd0);

        for (int n = 0; n < 3000; n++) begin
            for (int u = 0; u < 3; u++) begin
                vis_v[u] = ($urandom_range(0, 7) != 0);
                fs_v[u]  = ($urandom_range(0, 3) == 0);
                fr_v[u]  = ($urandom_range(0, 39) == 0);
                en_v[u]  = 8'($urandom);
                lay_v[u] = 104'({$urandom, $urandom, $urandom, $urandom});
                bg_v[u]  = 12'($urandom);
                fc_v[u]  = 12'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/draw_layers.md
Name: draw_layers

Overview:
- Parametrised N-layer pixel compositor for the VGA path. Sits between the per-object draw units (ball, blocks, paddle, background, etc.) and the RGB pins.
- Selects the highest-priority enabled layer with a valid pixel; otherwise outputs a background colour.
- Provides a frame-counted screen-flash effect (life lost / level clear) and reports which layer won, for collision/debug use.
- Two-stage pipeline; all outputs registered.

Parameters:
- NLAYERS, 4, number of input layers; layer 0 = highest priority; legal 1..8.
- CW, 3, colour width per pixel (3 = 1-bit R,G,B).
- FLASH_PERIOD, 8, frames per flash ON phase and per OFF phase; legal >=1.
- FLASH_BLINKS, 3, number of ON phases per flash request; legal >=1.
- Localparam IDW = max(1, clog2(NLAYERS)).

Ports:
- clock  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- visible  in  1  pixel is in the active display area.
- frame_start  in  1  one-cycle pulse, once per frame.
- layer_en  in  NLAYERS  per-layer enable mask; bit i gates layer i.
- in_layers  in  NLAYERS*(CW+1)  layer i occupies bits [i*(CW+1) +: CW+1] = {valid, colour[CW-1:0]}.
- bg_color  in  CW  colour shown when no layer hits.
- flash_req  in  1  one-cycle pulse; starts or restarts a flash sequence.
- flash_color  in  CW  colour substituted during flash ON phases.
- o_rgb  out  CW  final pixel colour.
- o_hit  out  1  an enabled layer was valid for this pixel.
- o_layer_id  out  IDW  index of the winning layer; 0 when o_hit=0.
- flash_active  out  1  flash state machine is not IDLE.

Behaviour:
- Reset: o_rgb=0, o_hit=0, o_layer_id=0, flash_active=0. Both pipeline stages are cleared, the FSM goes to IDLE, and the counters are zeroed. Reset mid-frame or mid-flash aborts everything immediately.
- Stage 1, registered each cycle:
  - hit_i = valid_i & layer_en[i].
  - The winner is the lowest i with hit_i. s1_color = winner colour, else bg_color.
  - s1_hit and s1_id hold the hit flag and winner index (0 if none); s1_vis = visible.
- Stage 2, registered each cycle:
  - If !s1_vis: o_rgb=0, o_hit=0, o_layer_id=0.
  - Otherwise o_hit=s1_hit and o_layer_id=s1_id. o_rgb = flash_color if the FSM is in FLASH_ON, else s1_color.
- Latency: 2 clocks from input to o_rgb/o_hit/o_layer_id. Flash substitution uses the FSM state at the stage-2 clock edge, with no alignment to stage 1.
- Flash FSM states: IDLE, FLASH_ON, FLASH_OFF. Registers: frame_cnt (clog2(FLASH_PERIOD+1) bits) and blinks_left (clog2(FLASH_BLINKS+1) bits).
  - flash_req in any state: go to FLASH_ON, frame_cnt=0, blinks_left=FLASH_BLINKS-1. flash_req has priority over a simultaneous frame_start, which is ignored that cycle.
  - FLASH_ON on frame_start:
    - If frame_cnt==FLASH_PERIOD-1: frame_cnt=0. If blinks_left==0 go to IDLE, else go to FLASH_OFF.
    - Otherwise frame_cnt++.
  - FLASH_OFF on frame_start:
    - If frame_cnt==FLASH_PERIOD-1: frame_cnt=0, blinks_left--, go to FLASH_ON.
    - Otherwise frame_cnt++.
  - IDLE ignores frame_start.
  - flash_active is registered and equals (state != IDLE), with the same timing as the state register.
  - A full sequence lasts (2*FLASH_BLINKS-1)*FLASH_PERIOD frame_start pulses after flash_req.
- Boundaries:
  - layer_en=0 gives bg_color with o_hit=0 even if all inputs are valid.
  - A disabled high-priority layer yields to the next enabled one.
  - Flash colour never appears in blanking (visible=0 gives 0).
  - NLAYERS=1 gives IDW=1 and o_layer_id is always 0.

Test Plan (NLAYERS=4, CW=3, FLASH_PERIOD=2, FLASH_BLINKS=2 unless stated):
1. Priority: layers 1 and 3 valid (colours 3'b101, 3'b010), layer_en=4'b1111, visible=1 -> two clocks later o_rgb=101, o_hit=1, o_layer_id=1. Then layer_en=4'b1101 -> o_rgb=010, o_layer_id=3.
2. Background/blank: no valid layers, bg_color=3'b001 -> o_rgb=001, o_hit=0, o_layer_id=0. Drop visible with layer 0 valid -> o_rgb=000, o_hit=0 exactly 2 clocks later.
3. Flash sequence: flash_req, flash_color=3'b111, layer 2 valid with 3'b100, then frame_start pulses -> o_rgb=111 for frames 0-1, 100 for frames 2-3, 111 for frames 4-5. flash_active drops on the 6th frame_start and o_rgb returns to 100.
4. Restart/collision: flash_req on the same cycle as frame_start while in FLASH_OFF -> FSM is FLASH_ON with frame_cnt=0 and blinks_left=1. The full 6-frame sequence repeats.
5. Reset mid-flash: assert reset during FLASH_ON with pixels streaming -> next cycle all outputs 0, flash_active=0. After release, the first pixel appears 2 clocks after input with no flash.
6. Parameter sweep: NLAYERS=1 and NLAYERS=8, CW=12, random valid/enable vectors against a scoreboard model -> o_rgb, o_hit and o_layer_id match the model with 2-cycle latency.
